// File: rtl/div8x4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider with a start/done handshake.
// Define DIV8X4_RADIX4_EN to retire two quotient bits per cycle instead of one.
module div8x4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

`ifdef DIV8X4_RADIX4_EN
   localparam logic [2:0] LAST_CNT = 3'd3;
`else
   localparam logic [2:0] LAST_CNT = 3'd7;
`endif

   state_t     state_q, state_d;
   logic [7:0] dvd_q, dvd_d;
   logic [3:0] dvs_q, dvs_d;
   logic [4:0] pr_q, pr_d;
   logic [7:0] acc_q, acc_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] quo_q, quo_d;
   logic [3:0] rem_q, rem_d;
   logic       dbz_q, dbz_d;

   logic [7:0] dvd_step;
   logic [4:0] pr_step;
   logic [7:0] acc_step;

   // One restoring step: returns {quotient bit, new partial remainder}.
   function automatic logic [5:0] rstep(input logic [4:0] pr, input logic b, input logic [3:0] d);
      logic [4:0] t;
      t = {pr[3:0], b};
      if (t >= {1'b0, d})
         rstep = {1'b1, t - {1'b0, d}};
      else
         rstep = {1'b0, t};
   endfunction

`ifdef DIV8X4_RADIX4_EN
   logic [5:0] s1, s2;
   always_comb begin
      s1       = rstep(pr_q, dvd_q[7], dvs_q);
      s2       = rstep(s1[4:0], dvd_q[6], dvs_q);
      pr_step  = s2[4:0];
      acc_step = {acc_q[5:0], s1[5], s2[5]};
      dvd_step = {dvd_q[5:0], 2'b00};
   end
`else
   logic [5:0] s1;
   always_comb begin
      s1       = rstep(pr_q, dvd_q[7], dvs_q);
      pr_step  = s1[4:0];
      acc_step = {acc_q[6:0], s1[5]};
      dvd_step = {dvd_q[6:0], 1'b0};
   end
`endif

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      pr_d    = pr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == 4'd0) begin
                  state_d = S_DONE;
                  quo_d   = 8'hFF;
                  rem_d   = 4'd0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  pr_d    = 5'd0;
                  acc_d   = 8'd0;
                  cnt_d   = 3'd0;
               end
            end
         end
         S_RUN: begin
            dvd_d = dvd_step;
            pr_d  = pr_step;
            acc_d = acc_step;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               quo_d   = acc_step;
               rem_d   = pr_step[3:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= 8'd0;
         dvs_q   <= 4'd0;
         pr_q    <= 5'd0;
         acc_q   <= 8'd0;
         cnt_q   <= 3'd0;
         quo_q   <= 8'd0;
         rem_q   <= 4'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         pr_q    <= pr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8x4.sv
// Directed self-checking bench for div8x4; expected results are hand-computed.
// Honours DIV8X4_RADIX4_EN for the expected latency.
module tb_div8x4;

`ifdef DIV8X4_RADIX4_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 8;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int failures = 0;

   div8x4 dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, ".busy"}, {15'd0, busy}, 16'd0);
      chk({tag, ".done"}, {15'd0, done}, 16'd0);
      chk({tag, ".quotient"}, {8'd0, quotient}, 16'd0);
      chk({tag, ".remainder"}, {12'd0, remainder}, 16'd0);
      chk({tag, ".dbz"}, {15'd0, div_by_zero}, 16'd0);
   endtask

   // Issue one division (edge 0 is the next rising edge) and check timing and result.
   task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 8'hA5;
      divisor  = 4'h0;
      for (int k = 1; k <= LAT; k++) begin
         chk({tag, ".busy_run"}, {15'd0, busy}, 16'd1);
         chk({tag, ".done_run"}, {15'd0, done}, 16'd0);
         @(posedge clk);
         #1;
      end
      chk({tag, ".done"}, {15'd0, done}, 16'd1);
      chk({tag, ".busy_done"}, {15'd0, busy}, 16'd0);
      chk({tag, ".quotient"}, {8'd0, quotient}, {8'd0, eq});
      chk({tag, ".remainder"}, {12'd0, remainder}, {12'd0, er});
      chk({tag, ".dbz"}, {15'd0, div_by_zero}, 16'd0);
      $display("div %0d/%0d -> q=%0d r=%0d dbz=%0b", a, b, quotient, remainder, div_by_zero);
      @(posedge clk);
      #1;
      chk({tag, ".done_drop"}, {15'd0, done}, 16'd0);
   endtask

   initial begin
      int ndone;
      int done_k;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4);
      do_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0);
      do_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0);
      do_div("d5_9", 8'd5, 4'd9, 8'd0, 4'd5);
      do_div("d0_3", 8'd0, 4'd3, 8'd0, 4'd0);

      // Divide by zero: result appears in the cycle after edge 0, busy never rises.
      dividend = 8'd37;
      divisor  = 4'd0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("dz.done", {15'd0, done}, 16'd1);
      chk("dz.dbz", {15'd0, div_by_zero}, 16'd1);
      chk("dz.quotient", {8'd0, quotient}, 16'h00FF);
      chk("dz.remainder", {12'd0, remainder}, 16'd0);
      chk("dz.busy", {15'd0, busy}, 16'd0);
      $display("div 37/0 -> q=%0h r=%0d dbz=%0b", quotient, remainder, div_by_zero);
      @(posedge clk);
      #1;
      chk("dz.done_drop", {15'd0, done}, 16'd0);
      chk("dz.busy_after", {15'd0, busy}, 16'd0);
      chk("dz.dbz_hold", {15'd0, div_by_zero}, 16'd1);
      do_div("d37_4", 8'd37, 4'd4, 8'd9, 4'd1);

      // Start during RUN is ignored: exactly one done, for 100/3.
      dividend = 8'd100;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      ndone  = 0;
      done_k = 0;
      for (int k = 1; k <= LAT + 8; k++) begin
         if (k == 3) begin
            dividend = 8'd50;
            divisor  = 4'd5;
            start    = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            ndone++;
            done_k = k;
         end
      end
      chk("ign.ndone", ndone[15:0], 16'd1);
      chk("ign.done_edge", done_k[15:0], LAT[15:0]);
      chk("ign.quotient", {8'd0, quotient}, 16'd33);
      chk("ign.remainder", {12'd0, remainder}, 16'd1);
      $display("div 100/3 (50/5 ignored) -> q=%0d r=%0d dones=%0d", quotient, remainder, ndone);

      // Back-to-back: start held in the DONE cycle of 200/7.
      do_div("b2b_first", 8'd200, 4'd7, 8'd28, 4'd4);
      do_div("b2b_prep", 8'd200, 4'd7, 8'd28, 4'd4);
      // do_div ends one cycle after done; rerun and hook the DONE cycle directly.
      dividend = 8'd200;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      chk("b2b.done1", {15'd0, done}, 16'd1);
      dividend = 8'd99;
      divisor  = 4'd10;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         chk("b2b.busy", {15'd0, busy}, 16'd1);
         chk("b2b.hold_q", {8'd0, quotient}, 16'd28);
         chk("b2b.hold_r", {12'd0, remainder}, 16'd4);
         @(posedge clk);
         #1;
      end
      chk("b2b.done2", {15'd0, done}, 16'd1);
      chk("b2b.quotient", {8'd0, quotient}, 16'd9);
      chk("b2b.remainder", {12'd0, remainder}, 16'd9);
      $display("div 99/10 back-to-back -> q=%0d r=%0d", quotient, remainder);
      @(posedge clk);
      #1;

      // Reset mid-run aborts without a done pulse.
      dividend = 8'd200;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rr.busy_before", {15'd0, busy}, 16'd1);
      chk("rr.q_before", {8'd0, quotient}, 16'd9);
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk_outs_zero("rr.reset");
      @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("rr.no_done", ndone[15:0], 16'd0);
      $display("reset mid-run -> q=%0d r=%0d dones=%0d", quotient, remainder, ndone);
      do_div("d64_8", 8'd64, 4'd8, 8'd8, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div8x4.md
# div8x4

Sequential 8-bit by 4-bit unsigned restoring divider: the inverse operation of the team's 4x4 multiplier. It recovers a 4-bit operand from an 8-bit product: quotient and remainder with `dividend = quotient*divisor + remainder`. It uses a start/done handshake and takes one quotient bit per cycle by default, or two per cycle when configured. It sits beside the multiplier in the arithmetic datapath.

## Interface
Parameters:
- None. Widths are fixed: dividend 8, divisor 4, quotient 8, remainder 4.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only while `busy`=0.
- `dividend` input 8: unsigned dividend; captured when `start` is accepted.
- `divisor` input 4: unsigned divisor; captured when `start` is accepted.
- `busy` output 1: high while an iteration is in progress (RUN state).
- `done` output 1: one-cycle pulse; results are valid from this pulse onward.
- `quotient` output 8: registered quotient; holds until the next completion.
- `remainder` output 4: registered remainder; holds until the next completion.
- `div_by_zero` output 1: registered; set with `done` when the divisor was 0.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset clears `busy`, `done`, `quotient`, `remainder`, `div_by_zero` and all internal registers to 0.
- Start acceptance: `start`=1 is accepted in IDLE or DONE (i.e. `busy`=0). `start` during RUN is ignored and not queued.
- Accepting with divisor≠0:
  - Capture operands into internal registers.
  - Clear the 5-bit partial remainder `pr`.
  - Set the iteration counter to 0.
  - Go to RUN.
- Accepting with divisor=0:
  - Go to DONE directly.
  - Set `quotient`=8'hFF, `remainder`=0, `div_by_zero`=1.
- RUN step, per quotient bit, MSB of the dividend first:
  - Form `pr = {pr[3:0], next dividend bit}`.
  - If `pr` ≥ divisor: subtract divisor and shift in quotient bit 1; otherwise shift in 0.
  - `pr` never exceeds 29, so 5 bits suffice; the final remainder < divisor fits 4 bits.
- Last RUN step:
  - Load `quotient` and `remainder` output registers.
  - Clear `div_by_zero`.
  - Go to DONE.
- DONE:
  - `done`=1 for exactly this one cycle.
  - Next state is IDLE, or RUN/DONE if a new `start` is accepted in this cycle (back-to-back).
- Outputs hold their values across IDLE and RUN. They are not cleared when a new operation starts.
- Operands on the input ports may change freely after acceptance.

## Timing
- Call the edge that accepts `start` edge 0.
- Default latency: RUN iterations on edges 1..8. Edge 8 loads the results and enters DONE, so `done` is high in the cycle after edge 8 and drops at edge 9.
- `busy`: high after edge 0 through edge 8. It is low in the DONE cycle.
- Divide-by-zero: `done` and `div_by_zero` are high in the cycle after edge 0. `busy` never rises.
- Throughput: one division per 9 cycles when `start` is reasserted in each DONE cycle.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No `done` pulse is produced for the aborted operation.

## Configuration
- `DIV8X4_RADIX4_EN` defined:
  - Each RUN cycle performs two chained restoring steps, giving 2 quotient bits per cycle.
  - 4 RUN iterations; results on edge 4; `done` in the cycle after edge 4.
  - Throughput: one division per 5 cycles.
- Undefined: radix-2, one bit per cycle, 8 iterations as above.
- Results, reset behaviour and divide-by-zero behaviour are identical in both builds.

## Test plan
- 200/7: `done` after edge 8 (edge 4 with the macro); `quotient`=28, `remainder`=4, `div_by_zero`=0; `busy` high edges 1–8.
- Corner operands: 255/15 → 17 r0; 255/1 → 255 r0; 5/9 → 0 r5; 0/3 → 0 r0.
- 37/0 → `done` and `div_by_zero`=1 in the cycle after edge 0, `quotient`=8'hFF, `remainder`=0, `busy` stays 0. A following 37/4 → 9 r1 and clears `div_by_zero`.
- `start` with 100/3 accepted; on edge 3 `start` is pulsed with 50/5 → exactly one `done`, giving 33 r1; the second request is ignored.
- `start` held high in the DONE cycle with 99/10 → the second result 9 r9 arrives 9 cycles later (5 with the macro). The first result, 200/7 → 28 r4, stays visible until then.
- `rst` pulsed on edge 4 of 200/7 → all outputs 0 immediately, no `done`. A subsequent 64/8 → 8 r0 with normal latency.
